// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream program loader driving the instruction memory write port
//
// Receives a frame (16-bit LE word count, 4*N data bytes LSB first, optional
// checksum byte) over a valid/ready handshake and writes each assembled
// 32-bit word to the instruction memory at byte address 4*k.
//
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (trailing checksum byte,
// sum of data bytes mod 256; mismatch sets error).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a session when idle
//   rx_data/valid/ready byte stream handshake
//   mem_we/addr/wdata   instruction memory write port (one-cycle strobe)
//   busy                session in progress
//   done, error         sticky session status, cleared by an accepted start
//   words_loaded        words written in the current or last session
module instr_mem_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CSUM
  } state_t;

  // One bit wider than the count so the capacity compare cannot overflow.
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  state_t      state;
  logic [7:0]  cnt_lo;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;     // bytes 0..2 of the word being assembled
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q;     // running sum of data bytes
`endif

  logic        accept;
  logic [15:0] n_total;

  // Every non-idle state takes bytes, so ready and busy are the same decode.
  assign rx_ready = (state != S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = rx_valid && rx_ready;
  assign n_total  = {rx_data, cnt_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt_lo       <= '0;
      word_cnt     <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
            state        <= S_CNT_LO;
          end
        end

        S_CNT_LO: begin
          if (accept) begin
            cnt_lo <= rx_data;
            state  <= S_CNT_HI;
          end
        end

        S_CNT_HI: begin
          if (accept) begin
            word_cnt <= n_total;
            if ({1'b0, n_total} > DEPTH_LIM) begin
              // Oversized image: reject before any write happens.
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (n_total == 16'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              done  <= 1'b1;
              state <= S_IDLE;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q <= sum_q + rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;  // wraps 3 -> 0 for the next word
            case (byte_idx)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                mem_we       <= 1'b1;
                mem_wdata    <= {rx_data, asm_q};
                mem_addr     <= ADDR_WIDTH'({word_idx, 2'b00});
                words_loaded <= word_idx + 16'd1;
                word_idx     <= word_idx + 16'd1;
                if (word_idx == word_cnt - 16'd1) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  done  <= 1'b1;
                  state <= S_IDLE;
`endif
                end
              end
            endcase
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            done  <= 1'b1;
            error <= (rx_data != sum_q);
            state <= S_IDLE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  instr_mem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] wl;
    bit          last;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  frame_q[$];
  bit          wend_q[$];
  logic [31:0] words_q[$];

  int   n_tests = 0;
  int   n_fail = 0;
  int   writes_seen = 0;
  bit   chk_en = 1'b0;
  bit   exp_we = 1'b0;
  bit   exp_done;
  bit   exp_err;
  logic [15:0] exp_wl;
  int   exp_writes;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: from word count and data words, derive the byte frame,
  // which byte completes a word, and the ordered list of memory writes.
  task automatic build_frame(input int n, input bit bad_csum);
    logic [7:0] s;
    frame_q.delete();
    wend_q.delete();
    exp_q.delete();
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    wend_q.push_back(1'b0);
    wend_q.push_back(1'b0);
    if (n > DEPTH) begin
      exp_done = 1'b1; exp_err = 1'b1; exp_wl = 16'd0; exp_writes = 0;
      return;
    end
    s = 8'd0;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(8'(words_q[k] >> (8 * b)));
        wend_q.push_back(b == 3);
        s = s + 8'(words_q[k] >> (8 * b));
      end
      exp_q.push_back('{addr: 32'(4 * k), data: words_q[k], wl: 16'(k + 1), last: (k == n - 1)});
    end
    exp_done = 1'b1; exp_err = 1'b0; exp_wl = 16'(n); exp_writes = n;
`ifdef INSTR_LOADER_CHECKSUM_EN
    frame_q.push_back(bad_csum ? s + 8'd1 : s);
    wend_q.push_back(1'b0);
    exp_err = bad_csum;
`endif
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int k = 0; k < n && k <= DEPTH; k++) words_q.push_back($urandom);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    writes_seen = 0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_ready", 64'(rx_ready), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
    check("start_err_clr", 64'(error), 64'd0);
    check("start_wl_clr", 64'(words_loaded), 64'd0);
  endtask

  // mode 0: every cycle, 1: valid every other cycle, 2: random gaps plus
  // stray start pulses while busy. stop_after < 0 sends the whole frame.
  task automatic send_frame(input int mode, input int stop_after);
    int  i = 0;
    int  cyc = 0;
    bit  v;
    while (i < frame_q.size() && (stop_after < 0 || i < stop_after)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        check("send_timeout", 64'(i), 64'(frame_q.size()));
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom % 3 != 0);
      endcase
      rx_valid = v;
      rx_data  = v ? frame_q[i] : 8'($urandom);
      start    = (mode == 2) && busy && ($urandom % 8 == 0);
      exp_we   = v && rx_ready && wend_q[i];
      if (v && rx_ready) i++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    exp_we   = 1'b0;
  endtask

  task automatic finish_session(input string name);
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_error"}, 64'(error), 64'(exp_err));
    check({name, "_wl"}, 64'(words_loaded), 64'(exp_wl));
    check({name, "_writes"}, 64'(writes_seen), 64'(exp_writes));
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Per-cycle compare, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("we_timing", 64'(mem_we), 64'(exp_we));
      check("ready_eq_busy", 64'(rx_ready), 64'(busy));
      check("addr_align", 64'(mem_addr[1:0]), 64'd0);
      if (mem_we) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(e.addr));
          check("wr_data", 64'(mem_wdata), 64'(e.data));
          check("wr_wl", 64'(words_loaded), 64'(e.wl));
          if (e.last) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            check("last_busy", 64'(busy), 64'd1);
            check("last_done", 64'(done), 64'd0);
`else
            check("last_busy", 64'(busy), 64'd0);
            check("last_done", 64'(done), 64'd1);
`endif
          end
        end
      end
    end
  end

  initial begin
    int n;
    int mode;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", 64'(rx_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_wl", 64'(words_loaded), 64'd0);
    rst_n = 1'b1;

    // Idle with valid held and no start: nothing accepted.
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (4) @(negedge clk);
    check("idle_ready", 64'(rx_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_wl", 64'(words_loaded), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    rx_valid = 1'b0;

    // Known two-word program, back-to-back.
    words_q = '{32'h00100513, 32'h00200593};
    build_frame(2, 1'b0);
    do_start();
    send_frame(0, -1);
    finish_session("b2b");
    check("b2b_hold_addr", 64'(mem_addr), 64'h4);
    check("b2b_hold_data", 64'(mem_wdata), 64'h00200593);
    check("b2b_wl_lit", 64'(words_loaded), 64'd2);

    // Same program, valid every other cycle.
    build_frame(2, 1'b0);
    do_start();
    send_frame(1, -1);
    finish_session("toggle");
    check("toggle_writes_lit", 64'(writes_seen), 64'd2);

    // N = 257 exceeds capacity.
    build_frame(257, 1'b0);
    do_start();
    send_frame(0, -1);
    finish_session("oversize");
    check("oversize_err_lit", 64'(error), 64'd1);
    check("oversize_writes_lit", 64'(writes_seen), 64'd0);

    // Reset after 6 data bytes: first word written, second aborted.
    rand_words(2);
    build_frame(2, 1'b0);
    do_start();
    send_frame(0, 8);
    rst_n = 1'b0;
    check("abort_one_written", 64'(writes_seen), 64'd1);
    exp_q.delete();
    #1;
    check("abort_we", 64'(mem_we), 64'd0);
    check("abort_addr", 64'(mem_addr), 64'd0);
    check("abort_wdata", 64'(mem_wdata), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_wl", 64'(words_loaded), 64'd0);
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("abort_no_more", 64'(writes_seen), 64'd1);
    rand_words(3);
    build_frame(3, 1'b0);
    do_start();
    send_frame(0, -1);
    finish_session("after_abort");

`ifdef INSTR_LOADER_CHECKSUM_EN
    words_q = '{32'h04030201};
    build_frame(1, 1'b0);
    check("csum_model_lit", 64'(frame_q[6]), 64'h0A);
    do_start();
    send_frame(0, -1);
    finish_session("csum_ok");
    check("csum_ok_err", 64'(error), 64'd0);
    build_frame(1, 1'b1);
    do_start();
    send_frame(0, -1);
    finish_session("csum_bad");
    check("csum_bad_err", 64'(error), 64'd1);
    check("csum_bad_data", 64'(mem_wdata), 64'h04030201);
`endif

    // Randomized sessions including capacity boundaries.
    for (int r = 0; r < 16; r++) begin
      case ($urandom % 8)
        0:       n = 0;
        1:       n = DEPTH;
        2:       n = DEPTH + 1;
        3:       n = $urandom_range(DEPTH + 2, 65535);
        default: n = $urandom_range(1, 6);
      endcase
      mode = $urandom_range(0, 2);
      rand_words(n);
      build_frame(n, ($urandom % 2) == 1);
      do_start();
      send_frame(mode, -1);
      finish_session("rand");
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side counterpart of the instruction memory. Receives a program image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives the instruction memory write port at word-aligned byte addresses. It holds `busy` for the whole session so the core can be kept in reset while the program is loaded.

## Interface
- `DEPTH_WORDS`, default 256: instruction memory capacity in words. The maximum accepted word count.
- `ADDR_WIDTH`, default 32: width of `mem_addr`, a byte address.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `start`  in  1  one-cycle pulse that begins a load session. Honoured only in IDLE.
- `rx_data`  in  8  stream byte
- `rx_valid`  in  1  `rx_data` is valid
- `rx_ready`  out  1  loader can accept a byte
- `mem_we`  out  1  one-cycle write strobe to the instruction memory
- `mem_addr`  out  ADDR_WIDTH  byte address, always a multiple of 4
- `mem_wdata`  out  32  assembled instruction word
- `busy`  out  1  load session in progress
- `done`  out  1  session completed. Sticky until the next accepted `start`.
- `error`  out  1  session failed. Sticky until the next accepted `start`.
- `words_loaded`  out  16  number of words written in the current or last session

## Operation
- Byte transfer: a byte is accepted on a rising edge where `rx_valid && rx_ready`.
- Frame format, in order:
  - count low byte
  - count high byte (N = 16-bit little-endian word count)
  - 4·N data bytes, least significant byte of each word first
  - with the macro only: 1 checksum byte
- States:
  - IDLE: `rx_ready`=0. An accepted `start` clears `done`, `error`, `words_loaded` and the byte counter, then goes to CNT_LO.
  - CNT_LO: takes the count low byte, then goes to CNT_HI.
  - CNT_HI: takes the count high byte.
    - If N > DEPTH_WORDS: `error`=1, `done`=1, go to IDLE. No writes occur.
    - Else if N=0: go to IDLE with `done`=1 (or to CSUM with the macro).
    - Else: go to DATA.
  - DATA: shifts bytes into a 32-bit assembly register, byte index 0..3.
    - On the edge accepting byte 3 of word k: `mem_wdata`←word, `mem_addr`←4·k, `mem_we`←1 for exactly one cycle, `words_loaded`←k+1.
    - If k=N−1: go to IDLE with `done`=1 (or to CSUM with the macro).
  - CSUM (macro only): takes one byte, sets `done`=1 and `error`=(byte ≠ running sum), then goes to IDLE.
- `rx_ready` is 1 in CNT_LO, CNT_HI, DATA and CSUM, and 0 otherwise.
- `busy` is 1 in every state except IDLE.
- `start` while `busy` is ignored. The stream is never stalled by writes; back-to-back bytes every cycle are sustained.
- Bytes presented in IDLE are not accepted and are not consumed.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE.
  - Outputs: `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `words_loaded`=0.
  - A partial word and the running sum are discarded. Reset mid-session aborts it without any further write.
- `start` edge → `busy`=1 and `rx_ready`=1 in the next cycle.
- Latency from the 4th byte to the write is 1 cycle: `mem_we` is registered and high in the cycle after the accepting edge.
- For the last word without the macro, `done` rises and `busy` falls in the same cycle as the final `mem_we`.
- `mem_addr` and `mem_wdata` hold their values after `mem_we` drops until the next write.
- Address arithmetic: k counts 0..N−1 and `mem_addr` = k·4 zero-extended. The maximum address is 4·(DEPTH_WORDS−1); there is no wrap-around because N is bounded.
- A `start` asserted in the same cycle as the session-ending edge is ignored, because the state is not yet IDLE.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN` defined:
  - The frame carries a trailing checksum byte, equal to the sum of all data bytes mod 256 (count bytes are excluded).
  - `done` rises only after the checksum byte is accepted.
  - `error`=1 on mismatch. Memory writes already performed are not undone.
- `INSTR_LOADER_CHECKSUM_EN` undefined: no CSUM state and no checksum byte; `error` is set only by N > DEPTH_WORDS.

## Test plan
- Reset then idle, `rx_valid`=1 with no `start` → `rx_ready`=0, no `mem_we`, all outputs 0.
- `start`, then bytes 02 00 13 05 10 00 93 05 20 00 streamed back-to-back → two writes: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593. `words_loaded`=2, `done`=1, `error`=0.
- Same frame with `rx_valid` toggled every other cycle → identical writes; `mem_we` strobes exactly twice.
- Count 01 01 (N=257, which exceeds DEPTH_WORDS) → `error`=1, `done`=1, zero writes, `busy`=0.
- `rst_n` pulsed low after 6 data bytes → no further `mem_we`, all outputs 0. A new `start` plus a full frame loads correctly from address 0.
- With the macro: frame 01 00 01 02 03 04 then checksum 0A → `done`=1, `error`=0. The same frame with checksum 0B → `done`=1, `error`=1, and the word 0x04030201 is still written.
